counter_run_sched: RTL and testbench
====================================

# counter_run_sched

Run scheduler for the 4-bit up-counter. Arbitrates round-robin between two requesters, each asking for a counted run of a given length. For the winner it clears the counter, enables it until `count` reaches the requested length, then signals completion. Sits between requesting control logic and the counter's `reset`/`enable` inputs, and observes the counter's `count` output.

## Interface
Parameters:
- `CW`, default 4: counter width, matching the counter's `count`.
- `TMO`, default 20: watchdog limit in RUN-state cycles. Used only when `CTRL_TIMEOUT_EN` is defined.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `req`, in, 2: run request per requester; level, held until `done` or `err`.
- `len0`, in, CW: run length for requester 0; sampled at grant.
- `len1`, in, CW: run length for requester 1; sampled at grant.
- `count`, in, CW: counter output.
- `cnt_clr`, out, 1: drives the counter `reset`; one-cycle pulse.
- `cnt_en`, out, 1: drives the counter `enable`.
- `gnt`, out, 2: one-hot grant, held from grant through DONE.
- `done`, out, 2: one-cycle completion pulse to the granted requester.
- `err`, out, 1: one-cycle abort pulse (timeout).
- `busy`, out, 1: high in any state other than IDLE.

## Operation
- States: IDLE, CLEAR, RUN, DONE.
- Reset values: state IDLE, `gnt`=0, `done`=0, `err`=0, `cnt_clr`=0, `cnt_en`=0, `busy`=0, round-robin pointer `last`=1 (requester 0 wins first).
- IDLE:
  - No `req` bit set: stay in IDLE.
  - One `req` bit set: grant that requester.
  - Both set: grant the requester other than `last`.
  - On grant: latch `len_q` from the winner's length input, set `gnt`, go to CLEAR.
- CLEAR: `cnt_clr`=1 for exactly one cycle, then go to RUN.
- RUN:
  - `cnt_en` = (`count` != `len_q`), combinational on the registered state and the `count` input.
  - When `count` == `len_q`, go to DONE.
  - With `len_q`=0, RUN lasts one cycle and `cnt_en` never rises.
- DONE:
  - `done[w]`=1 for one cycle, `gnt` held.
  - `last`<=w.
  - Next state IDLE; `gnt` clears on entry to IDLE.
- Requester drops `req` while granted (CLEAR or RUN):
  - Abort to IDLE next edge.
  - `cnt_en` low from the drop cycle on.
  - No `done`; `last` still updates.
- Widths: `len_q` and `count` are CW bits, compared unsigned. `len_q`=2^CW-1 is legal; the counter never wraps inside a run.
- Reset asserted mid-run: all outputs return to reset values immediately, asynchronously.

## Timing
- Cycle numbering: `req` seen high in IDLE at cycle 0.
- Cycle 1: `gnt` high, `cnt_clr`=1.
- Cycle 2: RUN begins with `count`=0.
- Cycles 2..1+L: `cnt_en` high (L cycles, where L=`len_q`).
- Cycle 2+L: `count`=L, `cnt_en`=0.
- Cycle 3+L: `done` pulse.
- Cycle 4+L: IDLE. The earliest next grant is visible at cycle 5+L, so back-to-back period is L+4 cycles.
- `req` arriving during a busy run is ignored until IDLE; no queueing beyond the level `req`.

## Configuration
- `CTRL_TIMEOUT_EN` defined:
  - RUN-cycle counter, clear on RUN entry.
  - If RUN lasts TMO cycles without `count`==`len_q`:
    - `cnt_en`=0.
    - `err`=1 for one cycle, `gnt` dropped, no `done`.
    - Next state IDLE; `last` updates.
- Not defined: no watchdog logic; `err` tied to 0; RUN waits indefinitely.

## Test plan
- Reset, then `req`=01, `len0`=3 -> `gnt`=01 at cycle 1; `cnt_clr` at cycle 1; `cnt_en` high in cycles 2–4; `count`=3 at cycle 5; `done`=01 at cycle 6.
- `req`=11 held, `len0`=2, `len1`=1 -> grants alternate 01, 10, 01; each `done` pulse matches the preceding grant.
- `len0`=0 -> `cnt_en` never high; `done`=01 at cycle 3.
- `len1`=15 -> 15 `cnt_en` cycles; `count`=15, no wrap to 0; `done`=10.
- `req` dropped in cycle 3 of a `len0`=5 run -> `cnt_en`=0 at cycle 3; IDLE at cycle 4; no `done`; `busy`=0.
- `CTRL_TIMEOUT_EN`, `TMO`=20, bench holds `count` at 0 with `len0`=4 -> `err` pulse after 20 RUN cycles; no `done`. Separately, `reset` asserted mid-RUN clears all outputs immediately.

Source files
------------

// File: rtl/counter_run_sched.sv
// ---------------------------------------------------------------------------
// counter_run_sched
//
// Run scheduler for the CW-bit up-counter. Two requesters ask for counted
// runs. A round-robin arbiter picks one winner. The scheduler then:
//   1. pulses the counter clear,
//   2. enables the counter until count reaches the winner's length,
//   3. pulses done back to the winner.
//
// Optional feature (compile-time macro CTRL_TIMEOUT_EN):
//   When defined, a watchdog aborts any RUN phase that lasts TMO cycles
//   without reaching the requested length. The abort is reported with err.
//   When undefined, err is tied low and RUN waits indefinitely.
//
// Parameters:
//   CW   counter width (matches the counter's count output)
//   TMO  watchdog limit in RUN cycles (used with CTRL_TIMEOUT_EN only)
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   req[1:0]   level request per requester, held until done or err
//   len0/len1  run length per requester, sampled at grant
//   count      counter output being observed
//   cnt_clr    one-cycle clear pulse to the counter's reset input
//   cnt_en     counter enable
//   gnt[1:0]   one-hot grant, held from grant through DONE
//   done[1:0]  one-cycle completion pulse to the granted requester
//   err        one-cycle abort pulse (watchdog timeout)
//   busy       high whenever the FSM is not IDLE
//   state_dbg  current FSM state, for observation only
//
// Handshake: a requester raises req[i] and holds it. The grant is visible
// the cycle after req is seen in IDLE. The requester keeps req high until
// it sees done[i] or err. Dropping req while granted (CLEAR or RUN) aborts
// the run on the next edge, with no done.
// ---------------------------------------------------------------------------
module counter_run_sched #(
    parameter int CW  = 4,
    parameter int TMO = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    req,
    input  logic [CW-1:0] len0,
    input  logic [CW-1:0] len1,
    input  logic [CW-1:0] count,
    output logic          cnt_clr,
    output logic          cnt_en,
    output logic [1:0]    gnt,
    output logic [1:0]    done,
    output logic          err,
    output logic          busy,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state, state_n;
    logic          last;        // requester that most recently finished/aborted
    logic [CW-1:0] len_q;
    logic          w;           // index of the granted requester
    logic          req_w;       // granted requester is still asking
    logic [1:0]    win;
    logic          grant_go;
    logic          release_go;
    logic          tmo_hit;
    logic          at_len;

    assign w         = gnt[1];
    assign req_w     = req[w];
    assign at_len    = (count == len_q);
    assign state_dbg = state;

`ifdef CTRL_TIMEOUT_EN
    localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;

    logic [TW-1:0] tmo_cnt;

    // Counts RUN cycles.
    // It is cleared while in CLEAR, so every run starts from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (state == CLEAR) begin
            tmo_cnt <= '0;
        end else if (state == RUN) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // High in the TMO-th RUN cycle.
    assign tmo_hit = (tmo_cnt == TW'(TMO - 1));
`else
    logic unused_cfg;
    assign unused_cfg = TMO[0];
    assign tmo_hit    = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and outputs
    always_comb begin
        state_n    = state;
        win        = 2'b00;
        grant_go   = 1'b0;
        release_go = 1'b0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        done       = 2'b00;
        err        = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    grant_go = 1'b1;
                    // With both requesting, the one that did not go last wins.
                    if (req == 2'b11) begin
                        win = last ? 2'b01 : 2'b10;
                    end else begin
                        win = req;
                    end
                    state_n = CLEAR;
                end
            end
            CLEAR: begin
                cnt_clr = 1'b1;
                if (!req_w) begin
                    release_go = 1'b1;
                    state_n    = IDLE;
                end else begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (!req_w) begin
                    // Aborted by the requester: enable drops in the same cycle.
                    release_go = 1'b1;
                    state_n    = IDLE;
                end else if (at_len) begin
                    state_n = DONE;
                end else if (tmo_hit) begin
                    err        = 1'b1;
                    release_go = 1'b1;
                    state_n    = IDLE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE: begin
                done       = gnt;
                release_go = 1'b1;
                state_n    = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Grant, latched length and round-robin pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt   <= 2'b00;
            len_q <= '0;
            last  <= 1'b1;
        end else if (grant_go) begin
            gnt   <= win;
            len_q <= win[1] ? len1 : len0;
        end else if (release_go) begin
            gnt  <= 2'b00;
            last <= w;
        end
    end

endmodule

// File: tb/tb_counter_run_sched.sv
module tb_counter_run_sched;

    logic       clk;
    logic       reset;
    logic [1:0] req;
    logic [3:0] len0;
    logic [3:0] len1;
    logic [3:0] count;
    logic       cnt_clr;
    logic       cnt_en;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       err;
    logic       busy;
    logic [1:0] state_dbg;
    logic       hold_cnt;

    int n_tests;
    int n_fail;

    counter_run_sched #(.CW(4), .TMO(20)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .len0      (len0),
        .len1      (len1),
        .count     (count),
        .cnt_clr   (cnt_clr),
        .cnt_en    (cnt_en),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counter under control ----------------
    // hold_cnt freezes the counter, so a run can never reach its length.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 4'd0;
        end else if (cnt_clr) begin
            count <= 4'd0;
        end else if (cnt_en && !hold_cnt) begin
            count <= count + 4'd1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One complete run, timed from the cycle in which IDLE sees req (cycle 0).
    task automatic run_one(input string tag, input logic [1:0] r, input logic [3:0] l0,
                           input logic [3:0] l1, input logic [1:0] eg, input int n_en,
                           input int dcyc);
        int         en_cnt, en_first, done_at;
        logic [1:0] g1, dval;
        logic       clr1;
        logic [3:0] cnt_at_done;
        en_cnt = 0; en_first = -1; done_at = -1;
        g1 = 2'b00; dval = 2'b00; clr1 = 1'b0; cnt_at_done = 4'd0;
        @(posedge clk); #1;
        req = r; len0 = l0; len1 = l1;
        for (int c = 0; c < 40 && done_at < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                g1   = gnt;
                clr1 = cnt_clr;
            end
            if (cnt_en) begin
                en_cnt++;
                if (en_first < 0) en_first = c;
            end
            if (done != 2'b00) begin
                done_at     = c;
                dval        = done;
                cnt_at_done = count;
            end
        end
        @(posedge clk); #1;
        req = 2'b00;
        @(negedge clk);
        check({tag, "_gnt_c1"}, 32'(g1), 32'(eg));
        check({tag, "_clr_c1"}, 32'(clr1), 32'd1);
        check({tag, "_en_cycles"}, en_cnt, n_en);
        check({tag, "_en_first"}, en_first, (n_en > 0) ? 2 : -1);
        check({tag, "_done_cycle"}, done_at, dcyc);
        check({tag, "_done_val"}, 32'(dval), 32'(eg));
        check({tag, "_count_end"}, 32'(cnt_at_done), n_en);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_gnt"}, 32'(gnt), 32'd0);
    endtask

    typedef struct {
        logic [1:0] r;
        logic [3:0] l0;
        logic [3:0] l1;
        logic [1:0] eg;
        int         n_en;
        int         dcyc;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [1:0] exp_q[$];
        int         exp_c[$];
        logic [1:0] e;
        int         saw_done;
        n_tests = 0; n_fail = 0;
        reset = 1'b1; req = 2'b00; len0 = 4'd0; len1 = 4'd0; hold_cnt = 1'b0;

        // Expected values, with the round-robin pointer carried from row to row.
        vecs[0] = '{r: 2'b01, l0: 4'd3,  l1: 4'd0,  eg: 2'b01, n_en: 3,  dcyc: 6};
        vecs[1] = '{r: 2'b01, l0: 4'd0,  l1: 4'd5,  eg: 2'b01, n_en: 0,  dcyc: 3};
        vecs[2] = '{r: 2'b10, l0: 4'd2,  l1: 4'd15, eg: 2'b10, n_en: 15, dcyc: 18};
        vecs[3] = '{r: 2'b10, l0: 4'd1,  l1: 4'd7,  eg: 2'b10, n_en: 7,  dcyc: 10};
        vecs[4] = '{r: 2'b11, l0: 4'd2,  l1: 4'd1,  eg: 2'b01, n_en: 2,  dcyc: 5};
        vecs[5] = '{r: 2'b11, l0: 4'd2,  l1: 4'd1,  eg: 2'b10, n_en: 1,  dcyc: 4};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnt",   32'(gnt),       32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_outs",  32'({cnt_clr, cnt_en, err, done}), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_idle", 32'({busy, gnt, done, cnt_clr, cnt_en, err}), 32'd0);

        // Table-driven runs
        for (int i = 0; i < 6; i++) begin
            run_one($sformatf("v%0d", i), vecs[i].r, vecs[i].l0, vecs[i].l1,
                    vecs[i].eg, vecs[i].n_en, vecs[i].dcyc);
        end

        // Both requesters held: grants alternate 01, 10, 01.
        exp_q = '{2'b01, 2'b10, 2'b01};
        exp_c = '{5, 10, 16};
        @(posedge clk); #1;
        req = 2'b11; len0 = 4'd2; len1 = 4'd1;
        for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            if (done != 2'b00) begin
                e = exp_q.pop_front();
                check("alt_done_val", 32'(done), 32'(e));
                check("alt_gnt_val",  32'(gnt),  32'(e));
                check("alt_done_cyc", c, exp_c.pop_front());
            end
        end
        @(posedge clk); #1;
        req = 2'b00;
        check("alt_all_seen", exp_q.size(), 0);
        @(negedge clk);
        check("alt_idle", 32'(busy), 32'd0);

        // Requester drops req in cycle 3 of a len0=5 run.
        saw_done = 0;
        @(posedge clk); #1;
        req = 2'b01; len0 = 4'd5;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done != 2'b00) saw_done++;
        end
        @(posedge clk); #1;
        req = 2'b00;
        @(negedge clk);
        check("drop_en_c3",   32'(cnt_en), 32'd0);
        check("drop_busy_c3", 32'(busy),   32'd1);
        if (done != 2'b00) saw_done++;
        @(negedge clk);
        check("drop_busy_c4",  32'(busy),      32'd0);
        check("drop_gnt_c4",   32'(gnt),       32'd0);
        check("drop_state_c4", 32'(state_dbg), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done != 2'b00) saw_done++;
        end
        check("drop_no_done", saw_done, 0);

`ifdef CTRL_TIMEOUT_EN
        // Counter frozen at 0 with len0=4: the watchdog fires in RUN cycle 20 (cycle 21).
        begin
            int err_at, err_cnt, en_cnt;
            err_at = -1; err_cnt = 0; en_cnt = 0; saw_done = 0;
            hold_cnt = 1'b1;
            @(posedge clk); #1;
            req = 2'b01; len0 = 4'd4;
            for (int c = 0; c < 40 && err_at < 0; c++) begin
                @(negedge clk);
                if (cnt_en) en_cnt++;
                if (done != 2'b00) saw_done++;
                if (err) begin
                    err_at = c;
                    err_cnt++;
                end
            end
            @(posedge clk); #1;
            req = 2'b00;
            @(negedge clk);
            if (err) err_cnt++;
            check("tmo_err_cycle", err_at,  21);
            check("tmo_err_width", err_cnt, 1);
            check("tmo_en_cycles", en_cnt,  19);
            check("tmo_no_done",   saw_done, 0);
            check("tmo_idle_gnt",  32'(gnt),  32'd0);
            check("tmo_idle_busy", 32'(busy), 32'd0);
            hold_cnt = 1'b0;
        end
`endif

        // Reset asserted mid-RUN clears outputs immediately.
        @(posedge clk); #1;
        req = 2'b10; len1 = 4'd9;
        repeat (5) @(negedge clk);
        check("mid_en_before",  32'(cnt_en), 32'd1);
        check("mid_gnt_before", 32'(gnt),    32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_gnt",   32'(gnt),       32'd0);
        check("mid_rst_busy",  32'(busy),      32'd0);
        check("mid_rst_outs",  32'({cnt_clr, cnt_en, err, done}), 32'd0);
        check("mid_rst_state", 32'(state_dbg), 32'd0);
        req = 2'b00;
        @(posedge clk); #1;
        reset = 1'b0;

        // The pointer is back at its reset value, so requester 0 wins a tie.
        run_one("post_mid_rst", 2'b11, 4'd0, 4'd0, 2'b01, 0, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
